// File: rtl/user_proj_systolic_nxn.sv
`ifndef MPRJ_IO_PADS
`define MPRJ_IO_PADS 38
`endif

// NxN output-stationary systolic matrix multiplier (C = A x B) behind a Wishbone slave.
// Operands enter skewed at the left/top edges and shift right/down one PE per cycle.
module user_proj_systolic_nxn #(
    parameter int N    = 2,
    parameter int DW   = 8,
    parameter int ACCW = 2*DW + $clog2(N)
) (
    input  logic                      wb_clk_i,
    input  logic                      wb_rst_i,
    input  logic                      wbs_stb_i,
    input  logic                      wbs_cyc_i,
    input  logic                      wbs_we_i,
    input  logic [3:0]                wbs_sel_i,
    input  logic [31:0]               wbs_dat_i,
    input  logic [31:0]               wbs_adr_i,
    output logic                      wbs_ack_o,
    output logic [31:0]               wbs_dat_o,
    input  logic [127:0]              la_data_in,
    output logic [127:0]              la_data_out,
    input  logic [127:0]              la_oenb,
    input  logic [`MPRJ_IO_PADS-1:0]  io_in,
    output logic [`MPRJ_IO_PADS-1:0]  io_out,
    output logic [`MPRJ_IO_PADS-1:0]  io_oeb,
    output logic [2:0]                irq
);
    localparam int NN = N*N;
    localparam int IW = (NN > 1) ? $clog2(NN) : 1;
    localparam int SW = $clog2(3*N);

    typedef enum logic [1:0] {S_IDLE, S_FEED, S_DRAIN, S_DONE} state_t;

    state_t          r_state, w_next;
    logic [SW-1:0]   r_step;
    logic [DW-1:0]   r_a [NN];
    logic [DW-1:0]   r_b [NN];
    logic [DW-1:0]   r_pa [NN];
    logic [DW-1:0]   r_pb [NN];
    logic [ACCW-1:0] r_acc [NN];
    logic [DW-1:0]   w_ain [NN];
    logic [DW-1:0]   w_bin [NN];
    logic            r_signed, r_irq_en, r_done, r_err, r_ack;
    logic [31:0]     r_dat, w_rdata;
    logic            w_valid, w_acc, w_wr, w_busy, w_feed, w_run, w_start, w_illegal;
    logic            w_is_ctrl, w_is_stat, w_is_a, w_is_b, w_is_c, w_in_mat;
    logic [11:0]     w_off;
    logic [IW-1:0]   w_idx;
    logic            w_unused;

    function automatic logic [ACCW-1:0] f_ext(input logic [DW-1:0] v, input logic sgn);
        logic [ACCW-1:0] e;
        if (sgn) e = ACCW'($signed(v));
        else     e = ACCW'(v);
        return e;
    endfunction

    assign w_off     = wbs_adr_i[11:0];
    assign w_idx     = w_off[IW+1:2];
    assign w_in_mat  = (w_off[1:0] == 2'b00) && (int'(w_off[7:2]) < NN);
    assign w_is_ctrl = (w_off == 12'h000);
    assign w_is_stat = (w_off == 12'h004);
    assign w_is_a    = (w_off[11:8] == 4'h1) && w_in_mat;
    assign w_is_b    = (w_off[11:8] == 4'h2) && w_in_mat;
    assign w_is_c    = (w_off[11:8] == 4'h3) && w_in_mat;

    // Each access is acked exactly once; the ack cycle itself blocks a second accept.
    assign w_valid   = wbs_stb_i & wbs_cyc_i;
    assign w_acc     = w_valid & ~r_ack;
    assign w_wr      = w_acc & wbs_we_i;
    assign w_busy    = (r_state != S_IDLE);
    assign w_feed    = (r_state == S_FEED);
    assign w_run     = (r_state == S_FEED) || (r_state == S_DRAIN);
    assign w_start   = w_wr & w_is_ctrl & wbs_dat_i[0] & ~w_busy;
    assign w_illegal = w_wr & w_busy & (w_is_ctrl | w_is_a | w_is_b);

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_start) w_next = S_FEED;
            S_FEED:  if (r_step == SW'(2*N-2)) w_next = S_DRAIN;
            S_DRAIN: if (r_step == SW'(3*N-2)) w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_state <= S_IDLE;
            r_step  <= '0;
        end else begin
            r_state <= w_next;
            if (w_start)    r_step <= '0;
            else if (w_run) r_step <= r_step + SW'(1);
        end
    end

    always_comb begin
        w_rdata = 32'hDEADBEEF;
        if (w_is_ctrl)      w_rdata = {29'd0, r_irq_en, r_signed, 1'b0};
        else if (w_is_stat) w_rdata = {29'd0, r_err, r_done, w_busy};
        else if (w_is_a)    w_rdata = 32'(r_a[w_idx]);
        else if (w_is_b)    w_rdata = 32'(r_b[w_idx]);
        else if (w_is_c) begin
            if (r_signed) w_rdata = 32'($signed(r_acc[w_idx]));
            else          w_rdata = 32'(r_acc[w_idx]);
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_ack    <= 1'b0;
            r_dat    <= '0;
            r_signed <= 1'b0;
            r_irq_en <= 1'b0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
            for (int p = 0; p < NN; p++) begin
                r_a[p] <= '0;
                r_b[p] <= '0;
            end
        end else begin
            r_ack <= w_acc;
            r_dat <= (w_acc && !wbs_we_i) ? w_rdata : 32'd0;
            if (w_wr && !w_busy) begin
                if (w_is_ctrl) begin
                    r_signed <= wbs_dat_i[1];
                    r_irq_en <= wbs_dat_i[2];
                end
                if (w_is_a) r_a[w_idx] <= wbs_dat_i[DW-1:0];
                if (w_is_b) r_b[w_idx] <= wbs_dat_i[DW-1:0];
            end
            // Setting a sticky flag takes priority over a same-edge W1C.
            if (r_state == S_DONE)                            r_done <= 1'b1;
            else if (w_start || (w_wr && w_is_stat && wbs_dat_i[1])) r_done <= 1'b0;
            if (w_illegal)                                    r_err <= 1'b1;
            else if (w_wr && w_is_stat && wbs_dat_i[2])       r_err <= 1'b0;
        end
    end

    always_comb begin
        for (int p = 0; p < NN; p++) begin
            w_ain[p] = '0;
            w_bin[p] = '0;
        end
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                if (j > 0) w_ain[IW'(i*N+j)] = r_pa[IW'(i*N + ((j > 0) ? j-1 : 0))];
                if (i > 0) w_bin[IW'(i*N+j)] = r_pb[IW'(((i > 0) ? i-1 : 0)*N + j)];
            end
        end
        // Edge skew: row i gets A[i][t-i], column j gets B[t-j][j].
        for (int i = 0; i < N; i++) begin
            if (w_feed && int'(r_step) >= i && int'(r_step) < i + N) begin
                w_ain[IW'(i*N)] = r_a[IW'(i*N + int'(r_step) - i)];
                w_bin[IW'(i)]   = r_b[IW'((int'(r_step) - i)*N + i)];
            end
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i || w_start) begin
            for (int p = 0; p < NN; p++) begin
                r_pa[p]  <= '0;
                r_pb[p]  <= '0;
                r_acc[p] <= '0;
            end
        end else if (w_run) begin
            for (int p = 0; p < NN; p++) begin
                r_pa[p]  <= w_ain[p];
                r_pb[p]  <= w_bin[p];
                r_acc[p] <= r_acc[p] + f_ext(w_ain[p], r_signed) * f_ext(w_bin[p], r_signed);
            end
        end
    end

    assign wbs_ack_o   = r_ack;
    assign wbs_dat_o   = r_dat;
    assign irq         = {2'b00, r_done & r_irq_en};
    assign la_data_out = '0;
    assign io_out      = '0;
    assign io_oeb      = '1;
    assign w_unused    = ^{wbs_sel_i, wbs_adr_i, wbs_dat_i, la_data_in, la_oenb, io_in};

endmodule

// File: tb/tb_user_proj_systolic_nxn.sv
`ifndef MPRJ_IO_PADS
`define MPRJ_IO_PADS 38
`endif

// Directed bench: one N=2 and one N=4 instance share the bus inputs; sel4 picks whose outputs are checked.
module tb_user_proj_systolic_nxn;
    localparam int IO = `MPRJ_IO_PADS;

    logic          clk = 1'b0;
    logic          rst, stb, cyc, we;
    logic [3:0]    sel;
    logic [31:0]   adr, wdat;
    logic [127:0]  la_in, la_oenb;
    logic [IO-1:0] io_in;

    logic          ack2, ack4;
    logic [31:0]   dat2, dat4;
    logic [127:0]  la_out2, la_out4;
    logic [IO-1:0] io_out2, io_out4, io_oeb2, io_oeb4;
    logic [2:0]    irq2, irq4;

    bit sel4 = 1'b0;
    int n_assert = 0;
    int n_fail = 0;
    int ma [4][4];
    int mb [4][4];

    wire        w_ack = sel4 ? ack4 : ack2;
    wire [31:0] w_dat = sel4 ? dat4 : dat2;

    always #5 clk = ~clk;

    user_proj_systolic_nxn #(.N(2), .DW(8)) dut2 (
        .wb_clk_i(clk), .wb_rst_i(rst), .wbs_stb_i(stb), .wbs_cyc_i(cyc), .wbs_we_i(we),
        .wbs_sel_i(sel), .wbs_dat_i(wdat), .wbs_adr_i(adr), .wbs_ack_o(ack2), .wbs_dat_o(dat2),
        .la_data_in(la_in), .la_data_out(la_out2), .la_oenb(la_oenb),
        .io_in(io_in), .io_out(io_out2), .io_oeb(io_oeb2), .irq(irq2));

    user_proj_systolic_nxn #(.N(4), .DW(8)) dut4 (
        .wb_clk_i(clk), .wb_rst_i(rst), .wbs_stb_i(stb), .wbs_cyc_i(cyc), .wbs_we_i(we),
        .wbs_sel_i(sel), .wbs_dat_i(wdat), .wbs_adr_i(adr), .wbs_ack_o(ack4), .wbs_dat_o(dat4),
        .la_data_in(la_in), .la_data_out(la_out4), .la_oenb(la_oenb),
        .io_in(io_in), .io_out(io_out4), .io_oeb(io_oeb4), .irq(irq4));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic bus(input logic w, input logic [11:0] a, input logic [31:0] d, output logic [31:0] rd);
        int k;
        @(negedge clk);
        stb = 1'b1; cyc = 1'b1; we = w; adr = {20'h0, a}; wdat = d;
        k = 0;
        do begin
            step();
            k++;
        end while (!w_ack && k < 8);
        rd = w_dat;
        check($sformatf("ack_%h", a), 32'(w_ack), 32'd1);
        stb = 1'b0; cyc = 1'b0; we = 1'b0;
    endtask

    task automatic wr(input logic [11:0] a, input logic [31:0] d);
        logic [31:0] t;
        bus(1'b1, a, d, t);
    endtask

    task automatic rdchk(input string tag, input logic [11:0] a, input logic [31:0] exp);
        logic [31:0] t;
        bus(1'b0, a, 32'd0, t);
        check(tag, t, exp);
    endtask

    task automatic wait_done(input string tag);
        logic [31:0] s;
        int k;
        k = 0;
        do begin
            bus(1'b0, 12'h004, 32'd0, s);
            k++;
        end while (s[1] == 1'b0 && k < 40);
        check(tag, 32'(s[1]), 32'd1);
    endtask

    task automatic load4();
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) begin
                wr(12'(12'h100 + 4*(r*4+c)), 32'(ma[r][c]) & 32'hFF);
                wr(12'(12'h200 + 4*(r*4+c)), 32'(mb[r][c]) & 32'hFF);
            end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; stb = 1'b0; cyc = 1'b0; we = 1'b0; sel = 4'hF;
        adr = '0; wdat = '0; la_in = '0; la_oenb = '1; io_in = '0;
        repeat (3) step();
        check("rst_ack", 32'(ack2), 32'd0);
        check("rst_dat", dat2, 32'd0);
        check("rst_irq2", 32'(irq2), 32'd0);
        check("rst_irq4", 32'(irq4), 32'd0);
        @(negedge clk) rst = 1'b0;
        rdchk("rst_status", 12'h004, 32'd0);
        rdchk("rst_ctrl", 12'h000, 32'd0);

        // N=2 unsigned: [[1,2],[3,4]] x [[5,6],[7,8]]
        wr(12'h100, 1); wr(12'h104, 2); wr(12'h108, 3); wr(12'h10C, 4);
        wr(12'h200, 5); wr(12'h204, 6); wr(12'h208, 7); wr(12'h20C, 8);
        rdchk("n2_a10", 12'h108, 32'd3);
        wr(12'h000, 32'h5);
        repeat (5) step();
        check("n2_irq_before", 32'(irq2), 32'd0);
        step();
        check("n2_irq_at_3n", 32'(irq2), 32'd1);
        rdchk("n2_status_done", 12'h004, 32'h2);
        rdchk("n2_c00", 12'h300, 32'd19);
        rdchk("n2_c01", 12'h304, 32'd22);
        rdchk("n2_c10", 12'h308, 32'd43);
        rdchk("n2_c11", 12'h30C, 32'd50);
        rdchk("n2_c_oob", 12'h310, 32'hDEADBEEF);
        wr(12'h000, 32'h0);
        check("n2_irq_masked", 32'(irq2), 32'd0);
        rdchk("n2_done_kept", 12'h004, 32'h2);
        wr(12'h000, 32'h4);
        check("n2_irq_unmasked", 32'(irq2), 32'd1);
        wr(12'h004, 32'h2);
        check("n2_irq_cleared", 32'(irq2), 32'd0);
        rdchk("n2_status_w1c", 12'h004, 32'd0);

        // START and A write while busy: acked, ignored, ERR set
        wr(12'h000, 32'h1);
        wr(12'h000, 32'h1);
        wr(12'h100, 32'd99);
        wait_done("n2_busy_done");
        rdchk("n2_status_err", 12'h004, 32'h6);
        rdchk("n2_busy_c00", 12'h300, 32'd19);
        rdchk("n2_busy_c01", 12'h304, 32'd22);
        rdchk("n2_busy_c10", 12'h308, 32'd43);
        rdchk("n2_busy_c11", 12'h30C, 32'd50);
        rdchk("n2_a00_kept", 12'h100, 32'd1);
        wr(12'h004, 32'h6);
        rdchk("n2_status_clr", 12'h004, 32'd0);

        // back-to-back strobes held high
        step();
        @(negedge clk);
        stb = 1'b1; cyc = 1'b1; we = 1'b0; adr = 32'h7F0;
        check("b2b_0", 32'(ack2), 32'd0);
        step();
        check("b2b_1", 32'(ack2), 32'd1);
        check("b2b_dat", dat2, 32'hDEADBEEF);
        step();
        check("b2b_2", 32'(ack2), 32'd0);
        check("b2b_dat_idle", dat2, 32'd0);
        step();
        check("b2b_3", 32'(ack2), 32'd1);
        stb = 1'b0; cyc = 1'b0;

        // N=4 signed: identity x (-(r*4+c))
        sel4 = 1'b1;
        repeat (20) step();
        wr(12'h004, 32'h6);
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) begin
                ma[r][c] = (r == c) ? 1 : 0;
                mb[r][c] = -(r*4+c);
            end
        load4();
        rdchk("n4_b33_zext", 12'h23C, 32'h0000_00F1);
        wr(12'h000, 32'h7);
        repeat (11) step();
        check("n4_irq_before", 32'(irq4), 32'd0);
        step();
        check("n4_irq_at_3n", 32'(irq4), 32'd1);
        rdchk("n4_ctrl", 12'h000, 32'h6);
        rdchk("n4_status", 12'h004, 32'h2);
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                rdchk($sformatf("n4_sgn_c%0d%0d", r, c), 12'(12'h300 + 4*(r*4+c)), 32'(-(r*4+c)));

        // N=4 unsigned all-ones
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) begin
                ma[r][c] = 255;
                mb[r][c] = 255;
            end
        load4();
        wr(12'h000, 32'h1);
        wait_done("n4_ff_done");
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                rdchk($sformatf("n4_ff_c%0d%0d", r, c), 12'(12'h300 + 4*(r*4+c)), 32'd260100);

        // reset during FEED with a read in flight
        wr(12'h004, 32'h6);
        wr(12'h000, 32'h5);
        step();
        @(negedge clk);
        stb = 1'b1; cyc = 1'b1; we = 1'b0; adr = 32'h300;
        rst = 1'b1;
        step();
        check("rst_mid_ack", 32'(ack4), 32'd0);
        check("rst_mid_irq", 32'(irq4), 32'd0);
        check("rst_mid_dat", dat4, 32'd0);
        @(negedge clk);
        rst = 1'b0; stb = 1'b0; cyc = 1'b0;
        step();
        check("rst_mid_ack2", 32'(ack4), 32'd0);
        rdchk("rst_mid_status", 12'h004, 32'd0);
        rdchk("rst_mid_ctrl", 12'h000, 32'd0);
        rdchk("rst_mid_c00", 12'h300, 32'd0);
        rdchk("rst_mid_c33", 12'h33C, 32'd0);
        rdchk("rst_mid_a00", 12'h100, 32'd0);
        rdchk("rst_mid_b33", 12'h23C, 32'd0);

        // full run after reset, checked against a plain matrix product
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) begin
                ma[r][c] = r + c + 1;
                mb[r][c] = (r*3 + c) % 7 + 1;
            end
        load4();
        wr(12'h000, 32'h1);
        wait_done("post_rst_done");
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) begin
                int e;
                e = 0;
                for (int k = 0; k < 4; k++) e += ma[r][k] * mb[k][c];
                rdchk($sformatf("post_rst_c%0d%0d", r, c), 12'(12'h300 + 4*(r*4+c)), 32'(e));
            end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/user_proj_systolic_nxn.md
Name: user_proj_systolic_nxn

Overview:
- Parametrised successor to the fixed 2x2 Wishbone systolic multiplier: computes C = A x B for NxN matrices of DW-bit elements on an NxN output-stationary PE grid.
- Sits in the Caravel user area as a Wishbone slave.
- Adds a start/busy/done FSM, signed/unsigned mode, a done interrupt, error flagging and a registered single-cycle ack.

Parameters:
- N, 2, matrix dimension (legal 2..4).
- DW, 8, element width in bits (legal 4..8).
- ACCW, 2*DW+$clog2(N), accumulator width (must be <= 32).

Ports:
- wb_clk_i  in  1  sole clock.
- wb_rst_i  in  1  reset, synchronous, active-high.
- wbs_stb_i, wbs_cyc_i, wbs_we_i  in  1 each  Wishbone strobe, cycle, write-enable.
- wbs_sel_i  in  4  byte selects; ignored, full-word access only.
- wbs_dat_i  in  32  write data.
- wbs_adr_i  in  32  address; only [11:0] decoded.
- wbs_ack_o  out  1  registered ack.
- wbs_dat_o  out  32  read data.
- la_data_in, la_oenb  in  128 each  unused.
- la_data_out  out  128  tied 0.
- io_in  in  `MPRJ_IO_PADS  unused.
- io_out  out  `MPRJ_IO_PADS  tied 0.
- io_oeb  out  `MPRJ_IO_PADS  tied all-1 (inputs).
- irq  out  3  irq[0] = done & IRQ_EN; irq[2:1] = 0.

Behaviour:
- Register map (byte offsets):
  - 0x000 CTRL (RW): bit0 START (write-1 pulse, reads 0), bit1 SIGNED, bit2 IRQ_EN.
  - 0x004 STATUS: bit0 BUSY (RO), bit1 DONE (sticky, W1C), bit2 ERR (sticky, W1C).
  - 0x100 + 4*(r*N+c): A[r][c], RW, low DW bits.
  - 0x200 + 4*(r*N+c): B[r][c], RW, low DW bits.
  - 0x300 + 4*(r*N+c): C[r][c], RO, ACCW bits, extended to 32 (sign-extended when SIGNED, else zero-extended).
  - Any other address: writes are dropped and acked; reads return 32'hDEADBEEF.
- Ack: for valid = stb & cyc, wbs_ack_o goes to 1 on the edge after valid is seen, for exactly one cycle. It is never asserted on two consecutive cycles. Writes take effect on the acking edge. wbs_dat_o is valid while ack = 1 and is 0 otherwise.
- FSM states IDLE, FEED, DRAIN, DONE:
  - IDLE -> FEED on the acking edge of a write with START = 1. The same edge clears all C accumulators and DONE.
  - FEED: step counter t = 0..2N-2. PE row i receives A[i][t-i] and PE column j receives B[t-j][j] when the index is in range, else 0 (skew). Operands propagate right/down one PE per cycle. Each PE does acc += a*b in ACCW bits, signed or unsigned per the SIGNED value latched at start.
  - DRAIN: N cycles, no new operands.
  - DRAIN -> DONE: sets DONE and clears BUSY. DONE -> IDLE on the next cycle.
  - Latency: DONE reads 1 exactly 3N cycles after the start-ack edge (6 cycles for N=2, 12 for N=4). BUSY = 1 throughout FEED/DRAIN.
- While BUSY:
  - START, A writes and B writes are acked but ignored, and set ERR.
  - CTRL SIGNED/IRQ_EN writes also set ERR and are ignored.
  - C reads return the partial accumulator value (undefined content, legal access).
- Arithmetic: no saturation; with the default ACCW it cannot overflow. A/B are stored with only the low DW bits; A/B readback is zero-extended.
- Reset (synchronous, at the wb_clk_i edge with wb_rst_i = 1), including mid-computation: FSM to IDLE; all A, B, C, CTRL and STATUS cleared to 0; wbs_ack_o = 0; wbs_dat_o = 0; irq = 0. Any in-flight bus cycle gets no ack.
- Simultaneous events: a DONE-setting edge and a W1C clearing DONE on the same edge leave DONE = 1 (set wins). The same rule applies to ERR.

Test Plan:
- N=2, DW=8, unsigned: A=[[1,2],[3,4]], B=[[5,6],[7,8]], START -> 6 cycles later DONE=1; C reads 19, 22, 43, 50; irq[0] = 1 only when IRQ_EN = 1.
- N=4, SIGNED=1: A = identity, B[r][c] = -(r*4+c) -> C equals B, read back sign-extended (C[3][3] = 32'hFFFFFFF1); A = B = all 8'hFF unsigned -> every C = 260100.
- START during BUSY plus a write to A[0][0] -> both acked, ERR = 1, result unchanged versus the no-interference run. Writing 0x6 to STATUS clears DONE and ERR.
- Back-to-back valid strobes held high -> ack pattern 0,1,0,1 (never two consecutive 1s). Read at 0x7F0 -> 32'hDEADBEEF.
- wb_rst_i pulsed during FEED -> next cycle BUSY = 0, DONE = 0, all C/A/B read 0, irq = 0. A subsequent full run gives correct results.
